noc_rr_pkt_arb: RTL and testbench
=================================

// Module: noc_rr_pkt_arb
// PURPOSE
//  Parametrised N-way round-robin arbiter for a switch output port. Arbitrates among N_REQ
//  input ports and holds the grant for a whole packet (head..tail flit), not a single cycle.
//  The grant is registered, so it appears one cycle after arbitration. The rotating pointer
//  moves past the winner on packet release. Drives the output-port crossbar select.
// PARAMETERS
//  N_REQ    4          number of requesters (>=2; need not be a power of two)
//  IDX_W    $clog2(N_REQ)  width of the index and pointer (derived; do not override)
//  WT_W     3          width of each per-requester weight (used only with ARB_WEIGHT_EN)
//  WEIGHTS  {N_REQ{3'd1}}  packed per-requester weight, [i*WT_W +: WT_W]; 0 is treated as 1
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous reset, active-low
//  req         in   N_REQ   requester i has a flit pending
//  req_tail    in   N_REQ   requester i's current flit is the tail (1-flit packet: head=tail)
//  out_ready   in   1       downstream accepts the granted flit this cycle
//  lock        in   1       1 = no new arbitration; an existing grant continues
//  grant       out  N_REQ   one-hot registered grant, or all-zero
//  grant_idx   out  IDX_W   binary index of grant (0 when grant==0)
//  grant_valid out  1       |grant
// BEHAVIOUR
//  - Reset (reset==0, async): grant=0, grant_idx=0, grant_valid=0, ptr=0, state=IDLE, credits reloaded.
//  - Transfer xfer = grant_valid & req[grant_idx] & out_ready. Release rel = xfer & req_tail[grant_idx].
//  - Arbitration: with ptr=p, the winner is the first i in order p, p+1, .., N_REQ-1, 0, .., p-1 with req[i]=1.
//    Wrap is mod N_REQ, with no aliasing for non-power-of-two N.
//  - States: IDLE (grant=0) and HOLD (grant one-hot).
//  - IDLE transitions:
//    - any req & !lock: next edge grant=winner, state -> HOLD (1-cycle latency).
//    - lock, or req==0: stay IDLE.
//  - HOLD, !rel: grant held unchanged.
//    - Applies under out_ready=0, under lock, and when the granted req deasserts mid-packet
//      (protocol violation; no release).
//  - HOLD, rel: ptr <= grant_idx+1 (mod N_REQ).
//    - Same cycle, re-arbitrate from the new ptr: if any req & !lock, the next edge loads the
//      new grant with no bubble (back-to-back packets).
//    - Otherwise grant=0 and state -> IDLE.
//  - req from the granted port that is released is eligible again only per the rotated order.
//    With N_REQ requesters all busy, each is served once per N packets.
//  - lock asserted in the same cycle as rel: release completes, ptr advances, grant -> 0, IDLE.
//  - Reset mid-packet: immediate grant=0. The packet is abandoned; upstream recovery is not this block's concern.
// CONFIGURATION
//  ARB_WEIGHT_EN defined: per-requester credit counter (WT_W bits), reloaded from WEIGHTS[i] at reset.
//  - On rel with credit[idx]>1 and req[idx] still 1 and !lock:
//    - regrant the same idx next cycle; credit[idx]--; ptr unchanged.
//  - Otherwise: ptr advances as above and credit[idx] reloads.
//  - Credits of non-granted ports are untouched.
//  ARB_WEIGHT_EN undefined: no counters or logic; every weight is effectively 1 (plain packet round-robin).
//  - WEIGHTS is ignored.
// STRUCTURE
//  noc_arb_pkg: typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t.
//  - Also holds function rr_rotate_pick(req, ptr) used for reuse in the input-VC arbiter.
//  Sub-module noc_rr_pick: combinational rotating-priority picker.
//  - Ports: req[N], ptr[IDX_W] -> any, idx[IDX_W].
//  - Implemented as a double-width req mask/first-one. Instantiated once.
//  Top: state/ptr/grant registers, xfer/rel decode, optional credit array.
// TESTING
//  1. Reset with req=4'b1111: grant=0, grant_valid=0. First edge after release of reset gives grant=4'b0001.
//  2. N_REQ=4, req=1111, req_tail=1111, out_ready=1: grant sequence 0001,0010,0100,1000,0001,
//     one per cycle, with no bubbles.
//  3. req0 sends a 3-flit packet (tail on 3rd) while req1=1: grant=0001 for 3 transfers.
//     grant=0010 on the edge after the tail transfer.
//  4. Tail presented with out_ready=0 for 4 cycles: grant held at 0001. Release one cycle after out_ready=1.
//  5. From IDLE, lock=1, req=0100: grant stays 0.
//     Deassert lock: grant=0100 next edge. Lock mid-packet: grant held to tail.
//  6. ARB_WEIGHT_EN, WEIGHTS idx0=2 (others 1), req=0011 with single-flit packets: grants 0,0,1,0,0,1.
//     Without the macro: 0,1,0,1. N_REQ=3 wrap check: 2->0.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Package: noc_arb_pkg
// Shared types and helpers for the NoC arbiters.
//  - arb_state_t    : packet-arbiter state (idle / holding a grant)
//  - rr_rotate_pick : loop-based rotating-priority pick, for reuse in the
//                     input-VC arbiter. It handles up to RR_MAX_N requesters,
//                     and the live count is passed in n.
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_MAX_W = $clog2(RR_MAX_N);

  typedef struct packed {
    logic                any;
    logic [RR_MAX_W-1:0] idx;
  } rr_pick_t;

  // The search starts at ptr and wraps modulo n. This requires ptr < n.
  function automatic rr_pick_t rr_rotate_pick(
    input logic [RR_MAX_N-1:0] req,
    input int unsigned         n,
    input int unsigned         ptr
  );
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      if ((i < n) && !r.any) begin
        k = ptr + i;
        if (k >= n) k = k - n;
        if (req[k]) begin
          r.any = 1'b1;
          r.idx = RR_MAX_W'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Module: noc_rr_pick
// Combinational rotating-priority picker. The winner is the first requester
// at or after ptr, wrapping modulo N_REQ.
// Ports:
//  req [N_REQ]  in   request vector
//  ptr [IDX_W]  in   highest-priority index (must be < N_REQ)
//  any          out  at least one request present
//  idx [IDX_W]  out  winning index (0 when no request)
module noc_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] low_mask;
  logic [2*N_REQ-1:0] masked;
  logic               found;

  // The request vector is duplicated, and bits below ptr are masked off.
  // The first set bit of the result is the wrapped winner. This avoids
  // aliasing when N_REQ is not a power of two.
  always_comb begin
    dbl      = {req, req};
    low_mask = '0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      low_mask[i] = (i >= 32'(ptr));
    end
    masked = dbl & low_mask;
    any    = |req;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = (i >= N_REQ) ? IDX_W'(i - N_REQ) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/noc_rr_pkt_arb.sv
// Module: noc_rr_pkt_arb
// Packet-level round-robin arbiter for a switch output port. A grant is
// registered, and it is held from the head flit to the tail flit. The
// rotating pointer moves past the winner when the packet is released.
// Optional feature: define ARB_WEIGHT_EN to enable per-requester credits
// (WEIGHTS). A credit lets a port send several consecutive packets.
// Ports:
//  clk          in   clock, rising edge
//  reset        in   asynchronous reset, active-low
//  req[N]       in   requester i has a flit pending
//  req_tail[N]  in   requester i's current flit is a tail
//  out_ready    in   downstream accepts the granted flit
//  lock         in   suppress new arbitration; an existing grant continues
//  grant[N]     out  one-hot registered grant, or zero
//  grant_idx    out  binary index of grant (0 when idle)
//  grant_valid  out  |grant
module noc_rr_pkt_arb
  import noc_arb_pkg::*;
#(
  parameter int unsigned           N_REQ   = 4,
  parameter int unsigned           IDX_W   = $clog2(N_REQ),
  parameter int unsigned           WT_W    = 3,
  parameter logic [N_REQ*WT_W-1:0] WEIGHTS = {N_REQ{3'd1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_tail,
  input  logic             out_ready,
  input  logic             lock,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer;
  logic             rel;
  logic             keep;

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == ARB_HOLD);

  assign xfer    = grant_valid & req[idx_q] & out_ready;
  assign rel     = xfer & req_tail[idx_q];
  assign idx_inc = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // On a release, arbitration uses the pointer that is about to be stored.
  // This lets back-to-back packets proceed without an idle cycle.
  assign pick_ptr = rel ? idx_inc : ptr_q;

  noc_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef ARB_WEIGHT_EN
  logic [WT_W-1:0] credit_q [N_REQ];

  function automatic logic [WT_W-1:0] weight_of(input logic [IDX_W-1:0] i);
    logic [WT_W-1:0] w;
    w = WEIGHTS[32'(i) * WT_W +: WT_W];
    return (w == '0) ? WT_W'(1) : w;
  endfunction

  // The port keeps the grant while it still has more than one credit left.
  // In that case the pointer does not move.
  assign keep = (credit_q[idx_q] > WT_W'(1)) & req[idx_q] & ~lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        credit_q[i] <= weight_of(IDX_W'(i));
      end
    end else if (rel) begin
      if (keep) credit_q[idx_q] <= credit_q[idx_q] - WT_W'(1);
      else      credit_q[idx_q] <= weight_of(idx_q);
    end
  end
`else
  logic unused_weights;
  assign unused_weights = ^WEIGHTS;
  assign keep = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any && !lock) begin
          state_d = ARB_HOLD;
          grant_d = N_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
        end
      end
      ARB_HOLD: begin
        if (rel && !keep) begin
          ptr_d = idx_inc;
          if (pick_any && !lock) begin
            grant_d = N_REQ'(1) << pick_idx;
            idx_d   = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_noc_rr_pkt_arb.sv
module tb_noc_rr_pkt_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, tail;
  logic       rdy, lck;
  logic [3:0] grant, grant_w;
  logic [1:0] gidx, gidx_w;
  logic       gval, gval_w;
  logic [2:0] req3, tail3, grant3;
  logic [1:0] gidx3;
  logic       gval3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  noc_rr_pkt_arb #(.N_REQ(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_tail(tail), .out_ready(rdy), .lock(lck),
    .grant(grant), .grant_idx(gidx), .grant_valid(gval));

  noc_rr_pkt_arb #(.N_REQ(4), .WT_W(3), .WEIGHTS({3'd1, 3'd1, 3'd1, 3'd2})) u_dutw (
    .clk(clk), .reset(reset), .req(req), .req_tail(tail), .out_ready(rdy), .lock(lck),
    .grant(grant_w), .grant_idx(gidx_w), .grant_valid(gval_w));

  noc_rr_pkt_arb #(.N_REQ(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_tail(tail3), .out_ready(rdy), .lock(lck),
    .grant(grant3), .grant_idx(gidx3), .grant_valid(gval3));

  typedef struct {
    logic [3:0] req;
    logic [3:0] tail;
    logic       rdy;
    logic       lck;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] t,
                              input logic rd, input logic lk, input logic [3:0] e);
    vec_t v;
    v.req = r; v.tail = t; v.rdy = rd; v.lck = lk; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] oh2idx(input logic [3:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_plain [6];
  logic [3:0] exp_wt    [6];
  logic [2:0] exp_n3    [6];

  initial begin
    reset = 1'b0;
    req = 4'b1111; tail = 4'b1111; rdy = 1'b1; lck = 1'b0;
    req3 = 3'b000; tail3 = 3'b000;

    // The grant stays at zero in reset, even with requests pending.
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(gval), 32'h0);
    check("rst_idx", 32'(gidx), 32'h0);
    check("rst_grant3", 32'(grant3), 32'h0);

    reset = 1'b1;
    tick();
    check("first_grant", 32'(grant), 32'h1);

    // All requesters busy with single-flit packets: the grant rotates with no idle cycles.
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b0010));
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b0100));
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b1000));
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 0, 4'b0001));
    // Three-flit packet from port 0 while port 1 is waiting.
    vecs.push_back(mk(4'b0011, 4'b0000, 1, 0, 4'b0001));
    vecs.push_back(mk(4'b0011, 4'b0000, 1, 0, 4'b0001));
    vecs.push_back(mk(4'b0011, 4'b0001, 1, 0, 4'b0010));
    // Tail presented with out_ready low: the grant is held.
    vecs.push_back(mk(4'b0011, 4'b0010, 1, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 0, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 1, 0, 4'b0100));
    // Lock together with a release goes to idle. Lock in idle blocks a new grant.
    vecs.push_back(mk(4'b0100, 4'b0100, 1, 1, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 1, 1, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 1, 1, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 1, 0, 4'b0100));
    // Lock mid-packet: the grant is held until the tail.
    vecs.push_back(mk(4'b0110, 4'b0000, 1, 1, 4'b0100));
    vecs.push_back(mk(4'b0110, 4'b0000, 1, 1, 4'b0100));
    vecs.push_back(mk(4'b0110, 4'b0100, 1, 1, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 0, 4'b0010));
    // The granted request drops mid-packet: the grant is held.
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 4'b0010));
    vecs.push_back(mk(4'b0001, 4'b0000, 1, 0, 4'b0010));
    vecs.push_back(mk(4'b0011, 4'b0010, 1, 0, 4'b0001));

    foreach (vecs[k]) begin
      req = vecs[k].req; tail = vecs[k].tail; rdy = vecs[k].rdy; lck = vecs[k].lck;
      tick();
      check($sformatf("vec%0d_grant", k), 32'(grant), 32'(vecs[k].exp));
      check($sformatf("vec%0d_idx", k), 32'(gidx), oh2idx(vecs[k].exp));
      check($sformatf("vec%0d_valid", k), 32'(gval), 32'(|vecs[k].exp));
    end

    // Asynchronous reset mid-packet clears the grant at once.
    req = 4'b0011; tail = 4'b0000; rdy = 1'b1; lck = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_valid", 32'(gval), 32'h0);
    check("async_rst_idx", 32'(gidx), 32'h0);
    tick(); tick();

    exp_plain = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`ifdef ARB_WEIGHT_EN
    exp_wt    = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
`else
    exp_wt    = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    exp_n3    = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    req = 4'b0011; tail = 4'b0011; rdy = 1'b1; lck = 1'b0;
    req3 = 3'b111; tail3 = 3'b111;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr2_%0d", k), 32'(grant), 32'(exp_plain[k]));
      check($sformatf("wt_%0d", k), 32'(grant_w), 32'(exp_wt[k]));
      check($sformatf("n3_%0d", k), 32'(grant3), 32'(exp_n3[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
